// File: rtl/serial_word_pkg.sv
// -----------------------------------------------------------------------------
// serial_word_pkg
// Shared definitions for the serial word deframer:
//   DEF_WORD_W / DEF_ADDR_W : default word and word-index widths
//   PAT_EVEN / PAT_ODD      : test pattern expected at even / odd word indices
//   ERR_W                   : width of the saturating mismatch counter
//   expected_word()         : pattern lookup by word-index parity
// -----------------------------------------------------------------------------
package serial_word_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam int ERR_W      = 8;

  localparam logic [7:0] PAT_EVEN = 8'hCC;
  localparam logic [7:0] PAT_ODD  = 8'hAA;

  // Expected pattern word for a given word index parity.
  function automatic logic [7:0] expected_word(input logic idx_lsb);
    logic [7:0] pat;
    if (idx_lsb) begin
      pat = PAT_ODD;
    end else begin
      pat = PAT_EVEN;
    end
    return pat;
  endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// -----------------------------------------------------------------------------
// serial_word_shifter
// LSB-first serial-to-parallel shifter with bit counter.
// Ports:
//   clk_i      : clock
//   clear_i    : synchronous active-high reset
//   sin_i      : serial data bit
//   sin_en_i   : bit strobe; sin_i is shifted in only when high
//   cand_o     : word that would be complete if this is the last bit
//                ({sin_i, sr[WORD_W-1:1]})
//   done_o     : completion strobe, high when the last bit of a word is
//                being sampled this cycle
// -----------------------------------------------------------------------------
module serial_word_shifter
  import serial_word_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic              sin_i,
  input  logic              sin_en_i,
  output logic [WORD_W-1:0] cand_o,
  output logic              done_o
);

  localparam int              CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Candidate word and completion are combinational so the top can register
  // the finished word on the same edge that samples its last bit.
  assign cand_o = {sin_i, sr_q[WORD_W-1:1]};
  assign done_o = sin_en_i && (cnt_q == LAST);

  // Next-state for shift register and bit counter; frozen while sin_en_i=0.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (sin_en_i) begin
      sr_d = {sin_i, sr_q[WORD_W-1:1]};
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_deframer.sv
// -----------------------------------------------------------------------------
// serial_word_deframer
// Reassembles LSB-first serial bits into words and presents each word with a
// running word index on a single-entry valid/ready output register.
// Optional pattern checker enabled by defining SERIAL_WORD_CHECK_EN: compares
// each completed word with CC (even index) / AA (odd index).
// Ports:
//   clk        : clock
//   clear      : synchronous active-high reset
//   sin        : serial data bit
//   sin_en     : bit strobe
//   word_out   : assembled word (LSB = first bit received)
//   word_addr  : index of word_out, counted from 0 since clear
//   word_valid : word_out/word_addr hold a word
//   word_ready : consumer accepts when word_valid && word_ready
//   overflow   : sticky, a completed word was dropped
//   mismatch   : one-cycle pulse with a newly loaded word that is not the
//                expected pattern (checker builds only, else 0)
//   err_cnt    : saturating mismatch count (checker builds only, else 0)
// -----------------------------------------------------------------------------
module serial_word_deframer
  import serial_word_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              sin,
  input  logic              sin_en,
  output logic [WORD_W-1:0] word_out,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt
);

  logic [WORD_W-1:0] cand_s;
  logic              done_s;
  logic              load_s;
  logic              drop_s;

  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  serial_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk_i    (clk),
    .clear_i  (clear),
    .sin_i    (sin),
    .sin_en_i (sin_en),
    .cand_o   (cand_s),
    .done_o   (done_s)
  );

  // A completed word loads if the holder is empty or being drained this
  // cycle; otherwise it is lost.
  assign load_s = done_s && (!valid_q || word_ready);
  assign drop_s = done_s && valid_q && !word_ready;

  // Next-state for word counter, output holder and overflow flag.
  always_comb begin
    wcnt_d  = wcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | drop_s;
    if (done_s) begin
      // Index advances even for dropped words so the gap is visible.
      wcnt_d = wcnt_q + ADDR_W'(1);
    end else begin
      wcnt_d = wcnt_q;
    end
    if (load_s) begin
      word_d  = cand_s;
      addr_d  = wcnt_q;
      valid_d = 1'b1;
    end else if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output holder, word counter and overflow registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      wcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign word_out   = word_q;
  assign word_addr  = addr_q;
  assign word_valid = valid_q;
  assign overflow   = ovf_q;

`ifdef SERIAL_WORD_CHECK_EN
  logic              bad_s;
  logic              mis_q, mis_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [WORD_W-1:0] exp_s;

  assign exp_s = WORD_W'(expected_word(wcnt_q[0]));
  // Every completed word is checked, including ones that get dropped.
  assign bad_s = done_s && (cand_s != exp_s);

  // Mismatch pulse accompanies a load; counter saturates at all-ones.
  always_comb begin
    mis_d = load_s && bad_s;
    err_d = err_q;
    if (bad_s && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      mis_q <= 1'b0;
      err_q <= '0;
    end else begin
      mis_q <= mis_d;
      err_q <= err_d;
    end
  end

  assign mismatch = mis_q;
  assign err_cnt  = err_q;
`else
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule
